// File: rtl/rvfi_trace_emitter.sv
// RVFI retirement trace emitter: pairs memory-stage records with retiring instructions.
// Optional RVFI_WIDE_EN macro enables the wide (two-share) destination write fields.
module rvfi_trace_emitter #(
  parameter int XL        = 31,
  parameter int MEM_DEPTH = 2
) (
  input  logic          g_clk,
  input  logic          g_reset,
  input  logic          mem_push,
  input  logic [XL:0]   mem_addr,
  input  logic [3:0]    mem_rmask,
  input  logic [3:0]    mem_wmask,
  input  logic [XL:0]   mem_wdata,
  input  logic [XL:0]   mem_rdata,
  output logic          mem_ready,
  input  logic          ret_valid,
  input  logic [XL:0]   ret_insn,
  input  logic [XL:0]   ret_pc,
  input  logic [XL:0]   ret_pc_next,
  input  logic          ret_trap,
  input  logic          ret_mem,
  input  logic [4:0]    ret_rs1_addr,
  input  logic [4:0]    ret_rs2_addr,
  input  logic [4:0]    ret_rs3_addr,
  input  logic [XL:0]   ret_rs1_rdata,
  input  logic [XL:0]   ret_rs2_rdata,
  input  logic [XL:0]   ret_rs3_rdata,
  input  logic [4:0]    ret_rd_addr,
  input  logic [XL:0]   ret_rd_wdata,
  input  logic          ret_rd_wide,
  input  logic [XL:0]   ret_rd_wdatahi,
  output logic          rvfi_valid,
  output logic [63:0]   rvfi_order,
  output logic [XL:0]   rvfi_insn,
  output logic [XL:0]   rvfi_pc_rdata,
  output logic [XL:0]   rvfi_pc_wdata,
  output logic          rvfi_trap,
  output logic          rvfi_intr,
  output logic [4:0]    rvfi_rs1_addr,
  output logic [4:0]    rvfi_rs2_addr,
  output logic [4:0]    rvfi_rs3_addr,
  output logic [XL:0]   rvfi_rs1_rdata,
  output logic [XL:0]   rvfi_rs2_rdata,
  output logic [XL:0]   rvfi_rs3_rdata,
  output logic [4:0]    rvfi_rd_addr,
  output logic [XL:0]   rvfi_rd_wdata,
  output logic          rvfi_rd_wide,
  output logic [XL:0]   rvfi_rd_wdatahi,
  output logic [XL:0]   rvfi_mem_addr,
  output logic [3:0]    rvfi_mem_rmask,
  output logic [3:0]    rvfi_mem_wmask,
  output logic [XL:0]   rvfi_mem_rdata,
  output logic [XL:0]   rvfi_mem_wdata,
  output logic          trace_err
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(MEM_DEPTH);

  logic [XL:0]   fifo_addr_r  [MEM_DEPTH];
  logic [3:0]    fifo_rmask_r [MEM_DEPTH];
  logic [3:0]    fifo_wmask_r [MEM_DEPTH];
  logic [XL:0]   fifo_wdata_r [MEM_DEPTH];
  logic [XL:0]   fifo_rdata_r [MEM_DEPTH];

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [63:0]   order_r;
  logic          intr_pend_r;

  logic          empty_s;
  logic          pop_s;
  logic          bypass_s;
  logic          underflow_s;
  logic          rd_en_s;
  logic          wr_en_s;
  logic          drop_s;
  logic [XL:0]   sel_addr_s;
  logic [3:0]    sel_rmask_s;
  logic [3:0]    sel_wmask_s;
  logic [XL:0]   sel_wdata_s;
  logic [XL:0]   sel_rdata_s;

  assign mem_ready   = (count_r != DEPTH_C);
  assign empty_s     = (count_r == '0);
  assign pop_s       = ret_valid && ret_mem;
  assign bypass_s    = pop_s && empty_s && mem_push;
  assign underflow_s = pop_s && empty_s && !mem_push;
  assign rd_en_s     = pop_s && !empty_s;
  // A pop frees the slot in the same cycle, so a full FIFO may still take a push.
  assign wr_en_s     = mem_push && !bypass_s && (mem_ready || rd_en_s);
  assign drop_s      = mem_push && !mem_ready && !rd_en_s;

`ifndef RVFI_WIDE_EN
  logic unused_wide_s;
  assign unused_wide_s = ret_rd_wide ^ (^ret_rd_wdatahi);
`endif

  // Selects the memory record paired with this retirement: queued, bypassed, or none.
  always_comb begin
    sel_addr_s  = '0;
    sel_rmask_s = 4'h0;
    sel_wmask_s = 4'h0;
    sel_wdata_s = '0;
    sel_rdata_s = '0;
    if (rd_en_s) begin
      sel_addr_s  = fifo_addr_r[rd_ptr_r];
      sel_rmask_s = fifo_rmask_r[rd_ptr_r];
      sel_wmask_s = fifo_wmask_r[rd_ptr_r];
      sel_wdata_s = fifo_wdata_r[rd_ptr_r];
      sel_rdata_s = fifo_rdata_r[rd_ptr_r];
    end else if (bypass_s) begin
      sel_addr_s  = mem_addr;
      sel_rmask_s = mem_rmask;
      sel_wmask_s = mem_wmask;
      sel_wdata_s = mem_wdata;
      sel_rdata_s = mem_rdata;
    end else begin
      sel_addr_s  = '0;
    end
  end

  // FIFO record storage; contents are don't-care until written.
  always_ff @(posedge g_clk) begin
    if (wr_en_s) begin
      fifo_addr_r[wr_ptr_r]  <= mem_addr;
      fifo_rmask_r[wr_ptr_r] <= mem_rmask;
      fifo_wmask_r[wr_ptr_r] <= mem_wmask;
      fifo_wdata_r[wr_ptr_r] <= mem_wdata;
      fifo_rdata_r[wr_ptr_r] <= mem_rdata;
    end
  end

  // FIFO control, bookkeeping and the registered trace packet.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      wr_ptr_r        <= '0;
      rd_ptr_r        <= '0;
      count_r         <= '0;
      order_r         <= 64'd0;
      intr_pend_r     <= 1'b0;
      trace_err       <= 1'b0;
      rvfi_valid      <= 1'b0;
      rvfi_order      <= 64'd0;
      rvfi_insn       <= '0;
      rvfi_pc_rdata   <= '0;
      rvfi_pc_wdata   <= '0;
      rvfi_trap       <= 1'b0;
      rvfi_intr       <= 1'b0;
      rvfi_rs1_addr   <= 5'd0;
      rvfi_rs2_addr   <= 5'd0;
      rvfi_rs3_addr   <= 5'd0;
      rvfi_rs1_rdata  <= '0;
      rvfi_rs2_rdata  <= '0;
      rvfi_rs3_rdata  <= '0;
      rvfi_rd_addr    <= 5'd0;
      rvfi_rd_wdata   <= '0;
      rvfi_rd_wide    <= 1'b0;
      rvfi_rd_wdatahi <= '0;
      rvfi_mem_addr   <= '0;
      rvfi_mem_rmask  <= 4'h0;
      rvfi_mem_wmask  <= 4'h0;
      rvfi_mem_rdata  <= '0;
      rvfi_mem_wdata  <= '0;
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (rd_en_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
      if (drop_s || underflow_s) trace_err <= 1'b1;

      rvfi_valid <= ret_valid;
      if (ret_valid) begin
        order_r        <= order_r + 64'd1;
        intr_pend_r    <= ret_trap;
        rvfi_order     <= order_r;
        rvfi_intr      <= intr_pend_r;
        rvfi_insn      <= ret_insn;
        rvfi_pc_rdata  <= ret_pc;
        rvfi_pc_wdata  <= ret_pc_next;
        rvfi_trap      <= ret_trap;
        rvfi_rs1_addr  <= ret_rs1_addr;
        rvfi_rs2_addr  <= ret_rs2_addr;
        rvfi_rs3_addr  <= ret_rs3_addr;
        rvfi_rs1_rdata <= ret_rs1_rdata;
        rvfi_rs2_rdata <= ret_rs2_rdata;
        rvfi_rs3_rdata <= ret_rs3_rdata;
        rvfi_rd_addr   <= ret_rd_addr;
        rvfi_rd_wdata  <= (ret_rd_addr == 5'd0) ? '0 : ret_rd_wdata;
`ifdef RVFI_WIDE_EN
        rvfi_rd_wide    <= ret_rd_wide;
        rvfi_rd_wdatahi <= ret_rd_wide ? ret_rd_wdatahi : '0;
`else
        rvfi_rd_wide    <= 1'b0;
        rvfi_rd_wdatahi <= '0;
`endif
        rvfi_mem_addr  <= ret_mem ? sel_addr_s  : '0;
        rvfi_mem_rmask <= ret_mem ? sel_rmask_s : 4'h0;
        rvfi_mem_wmask <= ret_mem ? sel_wmask_s : 4'h0;
        rvfi_mem_wdata <= ret_mem ? sel_wdata_s : '0;
        rvfi_mem_rdata <= ret_mem ? sel_rdata_s : '0;
      end
    end
  end

endmodule
